// File: rtl/ca_keystream_ctrl.sv
// Keystream sequencer for an N-cell hybrid cellular automaton: seed load,
// warm-up steps, then one bit per CA step over a valid/ready handshake.
module ca_keystream_ctrl #(
  parameter int               N        = 16,
  parameter logic [3*N-1:0]   RULE_VEC = {N{3'd5}},
  parameter int               WARMUP   = 32,
  parameter bit               CYCLIC   = 1'b0,
  parameter int               LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     seed,
  input  logic [LEN_W-1:0] len,
  output logic             ks_bit,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     ca_state
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WW-1:0] WARM_LAST = (WARMUP > 0) ? WW'(WARMUP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     ca_q, ca_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic [N+1:0]     ext;
  logic [N-1:0]     caNext;

  function automatic logic cellNext(input logic [2:0] rule,
                                    input logic a, input logic b, input logic c);
    case (rule)
      3'd1:    return a ^ b ^ c ^ (b & c);
      3'd2:    return a ^ b;
      3'd3:    return a ^ c;
      3'd4:    return a ^ (b & c);
      3'd5:    return a ^ b ^ c;
      3'd6:    return a ^ b ^ (b & c);
      3'd7:    return a ^ c ^ (b & c);
      default: return a;
    endcase
  endfunction

  // ext[i+1] is cell i; ext[0] and ext[N+1] are the boundary neighbours.
  assign ext = {(CYCLIC ? ca_q[0] : 1'b0), ca_q, (CYCLIC ? ca_q[N-1] : 1'b0)};

  always_comb begin
    caNext = ca_q;
    for (int i = 0; i < N; i++) begin
      caNext[i] = cellNext(RULE_VEC[3*i +: 3], ext[i+1], ext[i], ext[i+2]);
    end
  end

  always_comb begin
    state_d = state_q;
    ca_d    = ca_q;
    warm_d  = warm_q;
    rem_d   = rem_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_LOAD;
            ca_d    = seed;
            rem_d   = len;
            warm_d  = '0;
          end
        end
        S_LOAD: begin
          if (rem_q == '0)       state_d = S_DONE;
          else if (WARMUP == 0)  state_d = S_RUN;
          else                   state_d = S_WARMUP;
        end
        S_WARMUP: begin
          ca_d   = caNext;
          warm_d = warm_q + 1'b1;
          if (warm_q == WARM_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (ks_ready) begin
            ca_d  = caNext;
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ca_q    <= '0;
      warm_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ca_q    <= ca_d;
      warm_q  <= warm_d;
      rem_q   <= rem_d;
    end
  end

  // Valid is masked by abort so a concurrent ready never looks like a transfer.
  assign ks_valid = (state_q == S_RUN) && !abort;
  assign ks_bit   = ca_q[0];
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q == S_LOAD) || (state_q == S_WARMUP) || (state_q == S_RUN);
  assign ca_state = ca_q;

endmodule

// File: tb/tb_ca_keystream_ctrl.sv
// Directed bench for ca_keystream_ctrl using three 4-cell instances:
// A = rule 5 null boundary no warm-up, B = same with WARMUP=2, C = rule 2 cyclic.
module tb_ca_keystream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        ksReady;
  logic [3:0]  seed;
  logic [15:0] len;

  logic       ksBitA, ksValidA, busyA, doneA;
  logic       ksBitB, ksValidB, busyB, doneB;
  logic       ksBitC, ksValidC, busyC, doneC;
  logic [3:0] caA, caB, caC;
  logic [7:0] obsA, obsB, obsC;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       start;
    logic       ready;
    logic       abort;
    logic [7:0] expA;
    logic [7:0] expB;
  } vec_t;

  vec_t vecs[10];

  ca_keystream_ctrl #(.N(4), .RULE_VEC({4{3'd5}}), .WARMUP(0), .CYCLIC(1'b0), .LEN_W(16)) dutA (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .len(len),
    .ks_bit(ksBitA), .ks_valid(ksValidA), .ks_ready(ksReady),
    .busy(busyA), .done(doneA), .ca_state(caA));

  ca_keystream_ctrl #(.N(4), .RULE_VEC({4{3'd5}}), .WARMUP(2), .CYCLIC(1'b0), .LEN_W(16)) dutB (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .len(len),
    .ks_bit(ksBitB), .ks_valid(ksValidB), .ks_ready(ksReady),
    .busy(busyB), .done(doneB), .ca_state(caB));

  ca_keystream_ctrl #(.N(4), .RULE_VEC({4{3'd2}}), .WARMUP(0), .CYCLIC(1'b1), .LEN_W(16)) dutC (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .len(len),
    .ks_bit(ksBitC), .ks_valid(ksValidC), .ks_ready(ksReady),
    .busy(busyC), .done(doneC), .ca_state(caC));

  // Observation word: {valid, bit, done, busy, ca_state}
  assign obsA = {ksValidA, ksBitA, doneA, busyA, caA};
  assign obsB = {ksValidB, ksBitB, doneB, busyB, caB};
  assign obsC = {ksValidC, ksBitC, doneC, busyC, caC};

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic r, input logic a);
    @(negedge clk);
    start   = s;
    ksReady = r;
    abort   = a;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    ksReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runTable(input string tag);
    seed = 4'b0001;
    len  = 16'd4;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].start, vecs[i].ready, vecs[i].abort);
      checkOutput($sformatf("%s.row%0d.A", tag, i), obsA, vecs[i].expA);
      checkOutput($sformatf("%s.row%0d.B", tag, i), obsB, vecs[i].expB);
    end
  endtask

  initial begin
    logic [3:0] bpStates[4];
    logic [3:0] st;

    // Seed 0001, len 4: A streams 1,1,0,0; B warms up two steps then streams 0,0,1,1.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'b0_0_0_0_0000, 8'b0_0_0_0_0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'b0_1_0_1_0001, 8'b0_1_0_1_0001};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'b1_1_0_1_0001, 8'b0_1_0_1_0001};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'b1_1_0_1_0011, 8'b0_1_0_1_0011};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'b1_0_0_1_0100, 8'b1_0_0_1_0100};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'b1_0_0_1_1110, 8'b1_0_0_1_1110};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'b0_1_1_0_0101, 8'b1_1_0_1_0101};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 8'b0_1_0_0_0101, 8'b1_1_0_1_1101};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 8'b0_1_0_0_0101, 8'b0_1_1_0_0001};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 8'b0_1_0_0_0101, 8'b0_1_0_0_0001};
    bpStates = '{4'b0001, 4'b0011, 4'b0100, 4'b1110};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ksReady = 1'b0;
    seed = 4'b0; len = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.A", obsA, 8'b0);
    checkOutput("reset.B", obsB, 8'b0);
    checkOutput("reset.C", obsC, 8'b0);
    @(negedge clk);
    rst = 1'b0;

    runTable("basic");

    // Rule 2, cyclic boundary, single bit
    doReset();
    seed = 4'b0001; len = 16'd1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc.load", obsC, 8'b0_1_0_1_0001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc.run", obsC, 8'b1_1_0_1_0001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc.done", obsC, 8'b0_1_1_0_0011);

    // Backpressure: five stalled cycles before each accepted bit
    doReset();
    seed = 4'b0001; len = 16'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      st = bpStates[k];
      for (int j = 0; j < 5; j++) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("bp.stall%0d.%0d", k, j), obsA, {1'b1, st[0], 1'b0, 1'b1, st});
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("bp.take%0d", k), obsA, {1'b1, st[0], 1'b0, 1'b1, st});
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp.done", obsA, 8'b0_1_1_0_0101);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp.idle", obsA, 8'b0_1_0_0_0101);

    // Zero-length request goes straight from LOAD to DONE
    doReset();
    seed = 4'b0001; len = 16'd0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("len0.load", obsA, 8'b0_1_0_1_0001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("len0.done", obsA, 8'b0_1_1_0_0001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("len0.idle", obsA, 8'b0_1_0_0_0001);

    // start held high with a different seed/len while running
    doReset();
    seed = 4'b0001; len = 16'd4;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    seed = 4'b1010; len = 16'd2;
    for (int k = 0; k < 4; k++) begin
      st = bpStates[k];
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("restart.run%0d", k), obsA, {1'b1, st[0], 1'b0, 1'b1, st});
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart.done", obsA, 8'b0_1_1_0_0101);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restart.idle", obsA, 8'b0_1_0_0_0101);

    // Abort after two accepted bits, with ready high in the abort cycle
    doReset();
    seed = 4'b0001; len = 16'd4;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort.bit0", obsA, 8'b1_1_0_1_0001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort.bit1", obsA, 8'b1_1_0_1_0011);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort.cycle", obsA, 8'b0_0_0_1_0100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort.idle", obsA, 8'b0_0_0_0_0100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort.frozen", obsA, 8'b0_0_0_0_0100);

    // Asynchronous reset in the middle of warm-up, then a fresh run
    doReset();
    seed = 4'b0001; len = 16'd4;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("midrst.warmup", obsB, 8'b0_1_0_1_0001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst.async", obsB, 8'b0);
    @(negedge clk);
    rst = 1'b0;
    runTable("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ca_keystream_ctrl.md
Name: ca_keystream_ctrl

Overview:
Sequencer for an N-cell hybrid cellular-automaton (CA) register built from the team's 3-input rule cells. It loads a seed and runs a programmable number of warm-up steps. It then streams one keystream bit per CA step over a valid/ready handshake until a requested length is reached. It sits between the key/IV setup logic and the cipher's XOR stage.

Parameters:
N, 16, number of CA cells (N >= 3)
RULE_VEC, {N{3'd5}}, 3*N bits; bits [3i+2:3i] are the rule code of cell i
WARMUP, 32, CA steps run after seed load before the first output bit (0 allowed)
CYCLIC, 0, 0 = null boundary (out-of-range neighbours read 0); 1 = cyclic wrap
LEN_W, 16, width of the length request

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate the current run; any state
seed  in  N  initial CA state, captured when start is accepted
len  in  LEN_W  number of keystream bits to emit, captured with start
ks_bit  out  1  keystream bit, equal to state[0]
ks_valid  out  1  ks_bit is valid
ks_ready  in  1  consumer accepts ks_bit
busy  out  1  high in LOAD/WARMUP/RUN
done  out  1  one-cycle pulse after the last bit is accepted
ca_state  out  N  current CA register, for debug

Behaviour:
- Reset: FSM=IDLE; CA register, warm-up counter and remaining count all 0; ks_valid=0, busy=0, done=0.
- Cell function: a=s[i], b=s[i-1], c=s[i+1]. Boundary neighbours s[-1] and s[N] are 0 if CYCLIC=0, otherwise s[N-1] and s[0].
- Rule codes:
  - 1: a^b^c^(b&c)
  - 2: a^b
  - 3: a^c
  - 4: a^(b&c)
  - 5: a^b^c
  - 6: a^b^(b&c)
  - 7: a^c^(b&c)
  - 0: a (hold)
- One CA step updates all cells simultaneously from the old state.
- FSM states IDLE, LOAD, WARMUP, RUN, DONE:
  - IDLE: on start=1 (and abort=0), latch seed into the CA register, latch len into remaining, clear the warm-up counter, go to LOAD. start is ignored in every other state.
  - LOAD: 1 cycle, no step.
    - If len==0, go to DONE.
    - Else if WARMUP==0, go to RUN.
    - Else go to WARMUP.
  - WARMUP: one CA step per cycle, no output. After exactly WARMUP steps, go to RUN.
  - RUN: ks_valid=1 and ks_bit=state[0].
    - On ks_valid&ks_ready: perform one CA step and decrement remaining.
    - If remaining was 1, go to DONE.
    - With ks_ready=0, state, ks_bit and ks_valid hold unchanged; there is no timeout.
  - DONE: done=1 for one cycle, ks_valid=0, then IDLE.
- Latency: start accepted in cycle T gives the first ks_valid in cycle T+2+WARMUP.
- abort:
  - Highest priority: abort=1 in any non-IDLE state forces IDLE next cycle.
  - ks_valid drops, no step is taken in that cycle, no done pulse, CA register retained.
  - abort together with ks_ready in RUN: the bit is not consumed.
- Reset asserted mid-run returns all state to reset values asynchronously; the run is lost.
- busy=1 in LOAD, WARMUP and RUN; 0 in IDLE and DONE.
- Remaining counter is LEN_W wide with no wrap: len=2^LEN_W-1 emits exactly that many bits.

Test Plan:
1. N=4, rule 5 all cells, CYCLIC=0, WARMUP=0, seed=4'b0001, len=4, ks_ready=1 -> ks_bit sequence 1,1,0,0; ca_state 0001→0011→0100→1110→…; done pulses 1 cycle after the 4th handshake.
2. Same as 1 with WARMUP=2 -> first ks_valid 4 cycles after start; first bit is state[0] of 0100, i.e. 0.
3. N=4, rule 2 all cells, CYCLIC=1, seed=0001, len=1 -> ks_bit=1; after the handshake ca_state=0011 and done=1.
4. Backpressure: case 1 with ks_ready low for 5 cycles before each bit -> ks_valid and ks_bit hold stable; output sequence still 1,1,0,0; exactly 4 steps taken.
5. len=0 -> LOAD→DONE; done pulses with ks_valid never asserted. Also start asserted during RUN -> ignored.
6. abort during RUN after 2 bits -> IDLE next cycle, no done, ca_state frozen. Separately, rst asserted mid-WARMUP -> all outputs 0 immediately; a new start then behaves as in case 1.
